// File: rtl/axil_wb_bridge_if.sv
// Bundle of AXI4-Lite slave and Wishbone B4 master signals for axil_wb_bridge.
//   slave  : bridge view (AXI-Lite slave upstream, Wishbone master downstream)
//   master : view of whatever drives the bridge (AXI master + Wishbone slave)
// Signal names keep their original i_/o_ prefixes, which are taken from the
// bridge's point of view.
interface axil_wb_bridge_if #(
    parameter int AW = 28
);
    // write address
    logic          i_axi_awvalid;
    logic          o_axi_awready;
    logic [AW-1:0] i_axi_awaddr;
    logic [2:0]    i_axi_awprot;
    logic [3:0]    i_axi_awcache;
    // write data
    logic          i_axi_wvalid;
    logic          o_axi_wready;
    logic [31:0]   i_axi_wdata;
    logic [3:0]    i_axi_wstrb;
    // write response
    logic          o_axi_bvalid;
    logic          i_axi_bready;
    logic [1:0]    o_axi_bresp;
    // read address
    logic          i_axi_arvalid;
    logic          o_axi_arready;
    logic [AW-1:0] i_axi_araddr;
    logic [2:0]    i_axi_arprot;
    logic [3:0]    i_axi_arcache;
    // read data
    logic          o_axi_rvalid;
    logic          i_axi_rready;
    logic [31:0]   o_axi_rdata;
    logic [1:0]    o_axi_rresp;
    // wishbone
    logic          o_wb_cyc;
    logic          o_wb_stb;
    logic          o_wb_we;
    logic [AW-3:0] o_wb_addr;
    logic [31:0]   o_wb_data;
    logic [3:0]    o_wb_sel;
    logic          i_wb_stall;
    logic          i_wb_ack;
    logic          i_wb_err;
    logic [31:0]   i_wb_data;

    modport slave (
        input  i_axi_awvalid, i_axi_awaddr, i_axi_awprot, i_axi_awcache,
        output o_axi_awready,
        input  i_axi_wvalid, i_axi_wdata, i_axi_wstrb,
        output o_axi_wready,
        output o_axi_bvalid, o_axi_bresp,
        input  i_axi_bready,
        input  i_axi_arvalid, i_axi_araddr, i_axi_arprot, i_axi_arcache,
        output o_axi_arready,
        output o_axi_rvalid, o_axi_rdata, o_axi_rresp,
        input  i_axi_rready,
        output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        input  i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );

    modport master (
        output i_axi_awvalid, i_axi_awaddr, i_axi_awprot, i_axi_awcache,
        input  o_axi_awready,
        output i_axi_wvalid, i_axi_wdata, i_axi_wstrb,
        input  o_axi_wready,
        input  o_axi_bvalid, o_axi_bresp,
        output i_axi_bready,
        output i_axi_arvalid, i_axi_araddr, i_axi_arprot, i_axi_arcache,
        input  o_axi_arready,
        input  o_axi_rvalid, o_axi_rdata, o_axi_rresp,
        output i_axi_rready,
        input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_addr, o_wb_data, o_wb_sel,
        output i_wb_stall, i_wb_ack, i_wb_err, i_wb_data
    );
endinterface

// File: rtl/axil_wb_bridge.sv
// Single-outstanding AXI4-Lite slave to pipelined Wishbone B4 master bridge.
// Ports:
//   i_clk          clock, rising edge
//   i_axi_reset_n  asynchronous active-low reset
//   bus            axil_wb_bridge_if.slave: AXI-Lite AW/W/B/AR/R channels
//                  upstream, Wishbone master (cyc/stb/we/addr/data/sel,
//                  stall/ack/err/data) downstream
// AW, W and AR each have a one-entry holding register. One Wishbone
// transaction is on the bus at a time; every AXI request gets exactly one
// B or R response, with a bus timeout forcing SLVERR if the slave is silent.
module axil_wb_bridge #(
    parameter int C_AXI_ADDR_WIDTH = 28,
    parameter int TIMEOUT          = 8     // 2..15
) (
    input  logic             i_clk,
    input  logic             i_axi_reset_n,
    axil_wb_bridge_if.slave  bus
);
    localparam int AW = C_AXI_ADDR_WIDTH;
    localparam int C_AXI_DATA_WIDTH = 32;
    localparam int DW = C_AXI_DATA_WIDTH;
    localparam logic [3:0] TLAST = 4'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WB_WAIT, BRESP, RRESP} state_t;

    state_t          state;
    logic            ready_en;
    logic            last_grant;
    logic            aw_full, w_full, ar_full;
    logic [AW-3:0]   awaddr_q, araddr_q;
    logic [DW-1:0]   wdata_q;
    logic [3:0]      wstrb_q;
    logic [3:0]      timer;

    logic            wb_cyc, wb_stb, wb_we;
    logic [AW-3:0]   wb_addr;
    logic [DW-1:0]   wb_data;
    logic [3:0]      wb_sel;
    logic            bvalid, rvalid;
    logic [1:0]      bresp, rresp;
    logic [DW-1:0]   rdata;

    logic            awready, wready, arready;
    logic            wr_cand, rd_cand;
    logic            wb_done, wb_fail;
    logic [1:0]      resp_code;

    // readies are held low through reset and rise on the first edge after it
    assign awready = ready_en && !aw_full;
    assign wready  = ready_en && !w_full;
    assign arready = ready_en && !ar_full;

    assign wr_cand = aw_full && w_full;
    assign rd_cand = ar_full;

    // err beats ack; a timeout (neither present) also reports SLVERR
    assign wb_done   = bus.i_wb_ack || bus.i_wb_err || (timer == TLAST);
    assign wb_fail   = bus.i_wb_err || !bus.i_wb_ack;
    assign resp_code = wb_fail ? 2'b10 : 2'b00;

    always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
        if (!i_axi_reset_n) begin
            state      <= IDLE;
            ready_en   <= 1'b0;
            last_grant <= 1'b0;
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            ar_full    <= 1'b0;
            awaddr_q   <= '0;
            araddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            timer      <= '0;
            wb_cyc     <= 1'b0;
            wb_stb     <= 1'b0;
            wb_we      <= 1'b0;
            wb_addr    <= '0;
            wb_data    <= '0;
            wb_sel     <= '0;
            bvalid     <= 1'b0;
            rvalid     <= 1'b0;
            bresp      <= '0;
            rresp      <= '0;
            rdata      <= '0;
        end else begin
            ready_en <= 1'b1;

            if (bus.i_axi_awvalid && awready) begin
                aw_full  <= 1'b1;
                awaddr_q <= bus.i_axi_awaddr[AW-1:2];
            end
            if (bus.i_axi_wvalid && wready) begin
                w_full  <= 1'b1;
                wdata_q <= bus.i_axi_wdata;
                wstrb_q <= bus.i_axi_wstrb;
            end
            if (bus.i_axi_arvalid && arready) begin
                ar_full  <= 1'b1;
                araddr_q <= bus.i_axi_araddr[AW-1:2];
            end

            case (state)
                IDLE: begin
                    // last_grant flips only when both candidates compete, so an
                    // uncontested grant does not steal the other side's turn
                    if (wr_cand && (!rd_cand || !last_grant)) begin
                        wb_cyc  <= 1'b1;
                        wb_stb  <= 1'b1;
                        wb_we   <= 1'b1;
                        wb_addr <= awaddr_q;
                        wb_data <= wdata_q;
                        wb_sel  <= wstrb_q;
                        timer   <= '0;
                        state   <= WB_WAIT;
                        if (rd_cand)
                            last_grant <= 1'b1;
                    end else if (rd_cand) begin
                        wb_cyc  <= 1'b1;
                        wb_stb  <= 1'b1;
                        wb_we   <= 1'b0;
                        wb_addr <= araddr_q;
                        wb_sel  <= 4'hf;
                        timer   <= '0;
                        state   <= WB_WAIT;
                        if (wr_cand)
                            last_grant <= 1'b0;
                    end
                end
                WB_WAIT: begin
                    if (wb_stb && !bus.i_wb_stall)
                        wb_stb <= 1'b0;
                    if (wb_done) begin
                        wb_cyc <= 1'b0;
                        wb_stb <= 1'b0;
                        wb_we  <= 1'b0;
                        if (wb_we) begin
                            bresp  <= resp_code;
                            bvalid <= 1'b1;
                            state  <= BRESP;
                        end else begin
                            rresp  <= resp_code;
                            rdata  <= wb_fail ? '0 : bus.i_wb_data;
                            rvalid <= 1'b1;
                            state  <= RRESP;
                        end
                    end else begin
                        timer <= timer + 4'd1;
                    end
                end
                BRESP: begin
                    if (bus.i_axi_bready) begin
                        bvalid  <= 1'b0;
                        aw_full <= 1'b0;
                        w_full  <= 1'b0;
                        state   <= IDLE;
                    end
                end
                RRESP: begin
                    if (bus.i_axi_rready) begin
                        rvalid  <= 1'b0;
                        ar_full <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_axi_awready = awready;
    assign bus.o_axi_wready  = wready;
    assign bus.o_axi_arready = arready;
    assign bus.o_axi_bvalid  = bvalid;
    assign bus.o_axi_bresp   = bresp;
    assign bus.o_axi_rvalid  = rvalid;
    assign bus.o_axi_rresp   = rresp;
    assign bus.o_axi_rdata   = rdata;
    assign bus.o_wb_cyc      = wb_cyc;
    assign bus.o_wb_stb      = wb_stb;
    assign bus.o_wb_we       = wb_we;
    assign bus.o_wb_addr     = wb_addr;
    assign bus.o_wb_data     = wb_data;
    assign bus.o_wb_sel      = wb_sel;

    // protection/cache attributes and the byte offset carry no meaning here
    logic unused_inputs;
    assign unused_inputs = ^{bus.i_axi_awprot, bus.i_axi_awcache,
                             bus.i_axi_arprot, bus.i_axi_arcache,
                             bus.i_axi_awaddr[1:0], bus.i_axi_araddr[1:0]};
endmodule

// File: tb/tb_axil_wb_bridge.sv
// Testbench for axil_wb_bridge: AXI-Lite master driver, Wishbone slave model,
// and queues of expected Wishbone requests and AXI responses.
module tb_axil_wb_bridge;
    localparam int AW = 28;
    localparam int TO = 8;

    typedef struct packed {
        logic          we;
        logic [AW-3:0] addr;
        logic [31:0]   data;
        logic [3:0]    sel;
    } wb_exp_t;

    typedef struct packed {
        logic        is_wr;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } rsp_exp_t;

    logic clk;
    logic rst_n;

    axil_wb_bridge_if #(.AW(AW)) bus ();

    axil_wb_bridge #(
        .C_AXI_ADDR_WIDTH(AW),
        .TIMEOUT(TO)
    ) dut (
        .i_clk(clk),
        .i_axi_reset_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int rsp_seen = 0;

    wb_exp_t  wb_q[$];
    rsp_exp_t rsp_q[$];

    // Wishbone slave model configuration: 0 = ack, 1 = err, 2 = silent
    int          stall_n = 0;
    int          mode = 0;
    logic [31:0] rd_val = '0;
    int          last_cyc_len = 0;

    int   stall_cnt = 0;
    int   cyc_run = 0;
    bit   pending = 0;

    // Wishbone slave: decides stall/ack for the coming edge on each negedge
    always @(negedge clk) begin
        wb_exp_t e;
        if (!rst_n) begin
            bus.i_wb_ack   = 1'b0;
            bus.i_wb_err   = 1'b0;
            bus.i_wb_stall = 1'b0;
            pending   = 0;
            stall_cnt = 0;
            cyc_run   = 0;
        end else begin
            bus.i_wb_ack = 1'b0;
            bus.i_wb_err = 1'b0;
            if (pending) begin
                if (mode == 1) begin
                    bus.i_wb_err  = 1'b1;
                    bus.i_wb_data = 32'hBAD0_BAD0;
                end else begin
                    bus.i_wb_ack  = 1'b1;
                    bus.i_wb_data = rd_val;
                end
                pending = 0;
            end
            if (bus.o_wb_cyc) begin
                cyc_run++;
            end else if (cyc_run != 0) begin
                last_cyc_len = cyc_run;
                cyc_run = 0;
            end
            if (bus.o_wb_cyc && bus.o_wb_stb) begin
                if (stall_cnt < stall_n) begin
                    bus.i_wb_stall = 1'b1;
                    stall_cnt++;
                end else begin
                    bus.i_wb_stall = 1'b0;
                    stall_cnt = 0;
                    if (mode != 2) pending = 1;
                    total++;
                    if (wb_q.size() == 0) begin
                        bad++;
                        $display("FAIL wb_unexpected got we=%b addr=%h with no request queued",
                                 bus.o_wb_we, bus.o_wb_addr);
                    end else begin
                        e = wb_q.pop_front();
                        if (bus.o_wb_we !== e.we || bus.o_wb_addr !== e.addr ||
                            bus.o_wb_sel !== e.sel || (e.we && bus.o_wb_data !== e.data)) begin
                            bad++;
                            $display("FAIL wb_req got we=%b addr=%h data=%h sel=%h want we=%b addr=%h data=%h sel=%h",
                                     bus.o_wb_we, bus.o_wb_addr, bus.o_wb_data, bus.o_wb_sel,
                                     e.we, e.addr, e.data, e.sel);
                        end
                    end
                end
            end else begin
                bus.i_wb_stall = 1'b0;
            end
        end
    end

    // AXI response monitor: compares each B/R handshake with the queue head
    always @(negedge clk) begin
        rsp_exp_t r;
        if (rst_n) begin
            if (bus.o_axi_bvalid && bus.i_axi_bready) begin
                total++;
                rsp_seen++;
                if (rsp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b_unexpected got bresp=%b with nothing queued", bus.o_axi_bresp);
                end else begin
                    r = rsp_q.pop_front();
                    if (!r.is_wr || bus.o_axi_bresp !== r.resp) begin
                        bad++;
                        $display("FAIL b_resp got kind=write bresp=%b want kind_wr=%b resp=%b",
                                 bus.o_axi_bresp, r.is_wr, r.resp);
                    end
                end
            end
            if (bus.o_axi_rvalid && bus.i_axi_rready) begin
                total++;
                rsp_seen++;
                if (rsp_q.size() == 0) begin
                    bad++;
                    $display("FAIL r_unexpected got rresp=%b rdata=%h with nothing queued",
                             bus.o_axi_rresp, bus.o_axi_rdata);
                end else begin
                    r = rsp_q.pop_front();
                    if (r.is_wr || bus.o_axi_rresp !== r.resp || bus.o_axi_rdata !== r.rdata) begin
                        bad++;
                        $display("FAIL r_resp got kind=read rresp=%b rdata=%h want kind_wr=%b resp=%b rdata=%h",
                                 bus.o_axi_rresp, bus.o_axi_rdata, r.is_wr, r.resp, r.rdata);
                    end
                end
            end
        end
    end

    task automatic axi_issue(input bit do_aw, input bit do_w, input bit do_ar,
                             input logic [AW-1:0] awa, input logic [31:0] wd,
                             input logic [3:0] ws, input logic [AW-1:0] ara);
        bit aw_p, w_p, ar_p, aw_h, w_h, ar_h;
        int n;
        @(posedge clk); #2;
        aw_p = do_aw; w_p = do_w; ar_p = do_ar;
        if (do_aw) begin bus.i_axi_awvalid = 1'b1; bus.i_axi_awaddr = awa; end
        if (do_w)  begin bus.i_axi_wvalid = 1'b1; bus.i_axi_wdata = wd; bus.i_axi_wstrb = ws; end
        if (do_ar) begin bus.i_axi_arvalid = 1'b1; bus.i_axi_araddr = ara; end
        n = 0;
        while ((aw_p || w_p || ar_p) && n < 50) begin
            @(negedge clk);
            aw_h = aw_p && bus.o_axi_awready;
            w_h  = w_p  && bus.o_axi_wready;
            ar_h = ar_p && bus.o_axi_arready;
            @(posedge clk); #2;
            if (aw_h) begin aw_p = 0; bus.i_axi_awvalid = 1'b0; end
            if (w_h)  begin w_p  = 0; bus.i_axi_wvalid  = 1'b0; end
            if (ar_h) begin ar_p = 0; bus.i_axi_arvalid = 1'b0; end
            n++;
        end
        total++;
        if (aw_p || w_p || ar_p) begin
            bad++;
            $display("FAIL issue_timeout got pending aw=%b w=%b ar=%b want all accepted", aw_p, w_p, ar_p);
            bus.i_axi_awvalid = 1'b0;
            bus.i_axi_wvalid  = 1'b0;
            bus.i_axi_arvalid = 1'b0;
        end
    endtask

    task automatic wait_resp(input int n);
        int target;
        int k;
        target = rsp_seen + n;
        k = 0;
        while (rsp_seen < target && k < 200) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (rsp_seen < target) begin
            bad++;
            $display("FAIL resp_timeout got %0d responses want %0d", rsp_seen, target);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (bus.o_axi_awready !== 1'b0 || bus.o_axi_wready !== 1'b0 || bus.o_axi_arready !== 1'b0 ||
            bus.o_axi_bvalid !== 1'b0 || bus.o_axi_rvalid !== 1'b0 || bus.o_wb_cyc !== 1'b0 ||
            bus.o_wb_stb !== 1'b0 || bus.o_wb_we !== 1'b0 || bus.o_axi_bresp !== 2'b00 ||
            bus.o_axi_rresp !== 2'b00 || bus.o_axi_rdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_outputs got rdy=%b%b%b bv=%b rv=%b cyc=%b stb=%b we=%b want all 0",
                     bus.o_axi_awready, bus.o_axi_wready, bus.o_axi_arready, bus.o_axi_bvalid,
                     bus.o_axi_rvalid, bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.o_axi_arready !== 1'b0) begin
            bad++;
            $display("FAIL ready_before_edge got arready=%b want 0", bus.o_axi_arready);
        end
        @(negedge clk);
        total++;
        if (bus.o_axi_awready !== 1'b1 || bus.o_axi_wready !== 1'b1 || bus.o_axi_arready !== 1'b1) begin
            bad++;
            $display("FAIL ready_after_edge got rdy=%b%b%b want 111",
                     bus.o_axi_awready, bus.o_axi_wready, bus.o_axi_arready);
        end
    endtask

    task automatic test_single_write();
        mode = 0; stall_n = 0;
        wb_q.push_back('{we: 1'b1, addr: 26'h40, data: 32'hDEADBEEF, sel: 4'hC});
        rsp_q.push_back('{is_wr: 1'b1, resp: 2'b00, rdata: 32'h0});
        axi_issue(1, 1, 0, 28'h100, 32'hDEADBEEF, 4'hC, '0);
        @(negedge clk);  // cycle 0
        total++;
        if (bus.o_wb_stb !== 1'b0) begin
            bad++;
            $display("FAIL wr_stb_cycle0 got stb=%b want 0", bus.o_wb_stb);
        end
        @(negedge clk);  // cycle 1
        total++;
        if (bus.o_wb_cyc !== 1'b1 || bus.o_wb_stb !== 1'b1 || bus.o_wb_we !== 1'b1) begin
            bad++;
            $display("FAIL wr_stb_cycle1 got cyc=%b stb=%b we=%b want 111",
                     bus.o_wb_cyc, bus.o_wb_stb, bus.o_wb_we);
        end
        @(negedge clk);  // cycle 2
        total++;
        if (bus.o_axi_bvalid !== 1'b0) begin
            bad++;
            $display("FAIL wr_bvalid_cycle2 got bvalid=%b want 0", bus.o_axi_bvalid);
        end
        @(negedge clk);  // cycle 3
        total++;
        if (bus.o_axi_bvalid !== 1'b1 || bus.o_axi_bresp !== 2'b00) begin
            bad++;
            $display("FAIL wr_bvalid_cycle3 got bvalid=%b bresp=%b want 1/00",
                     bus.o_axi_bvalid, bus.o_axi_bresp);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_read_stall();
        int stb_cnt;
        bit got;
        mode = 0; stall_n = 2; rd_val = 32'h12345678;
        wb_q.push_back('{we: 1'b0, addr: 26'h2, data: 32'h0, sel: 4'hF});
        rsp_q.push_back('{is_wr: 1'b0, resp: 2'b00, rdata: 32'h12345678});
        axi_issue(0, 0, 1, '0, '0, '0, 28'h8);
        stb_cnt = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.o_wb_stb) stb_cnt++;
            if (bus.o_axi_rvalid) begin
                got = 1;
            end else begin
                total++;
                if (bus.o_axi_arready !== 1'b0) begin
                    bad++;
                    $display("FAIL rd_arready_held got arready=%b want 0", bus.o_axi_arready);
                end
            end
        end
        total++;
        if (!got || stb_cnt != 3) begin
            bad++;
            $display("FAIL rd_stall got rvalid_seen=%0d stb_cycles=%0d want 1 and 3", got, stb_cnt);
        end
        @(posedge clk); #2;
        @(negedge clk);
        total++;
        if (bus.o_axi_arready !== 1'b1 || bus.o_axi_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL rd_after_hs got arready=%b rvalid=%b want 1/0", bus.o_axi_arready, bus.o_axi_rvalid);
        end
        stall_n = 0;
    endtask

    task automatic test_arbitration();
        mode = 0; stall_n = 0; rd_val = 32'h5555AAAA;
        wb_q.push_back('{we: 1'b1, addr: 26'h100, data: 32'h01020304, sel: 4'hF});
        wb_q.push_back('{we: 1'b0, addr: 26'h101, data: 32'h0, sel: 4'hF});
        rsp_q.push_back('{is_wr: 1'b1, resp: 2'b00, rdata: 32'h0});
        rsp_q.push_back('{is_wr: 1'b0, resp: 2'b00, rdata: 32'h5555AAAA});
        axi_issue(1, 1, 1, 28'h400, 32'h01020304, 4'hF, 28'h404);
        wait_resp(2);
        wb_q.push_back('{we: 1'b0, addr: 26'h101, data: 32'h0, sel: 4'hF});
        wb_q.push_back('{we: 1'b1, addr: 26'h100, data: 32'hA0B0C0D0, sel: 4'h5});
        rsp_q.push_back('{is_wr: 1'b0, resp: 2'b00, rdata: 32'h5555AAAA});
        rsp_q.push_back('{is_wr: 1'b1, resp: 2'b00, rdata: 32'h0});
        axi_issue(1, 1, 1, 28'h400, 32'hA0B0C0D0, 4'h5, 28'h404);
        wait_resp(2);
        total++;
        if (wb_q.size() != 0 || rsp_q.size() != 0) begin
            bad++;
            $display("FAIL arb_drain got wb_q=%0d rsp_q=%0d want 0/0", wb_q.size(), rsp_q.size());
        end
    endtask

    task automatic test_error_timeout();
        stall_n = 0;
        mode = 1;
        wb_q.push_back('{we: 1'b1, addr: 26'h4, data: 32'hAAAA5555, sel: 4'hF});
        rsp_q.push_back('{is_wr: 1'b1, resp: 2'b10, rdata: 32'h0});
        axi_issue(1, 1, 0, 28'h10, 32'hAAAA5555, 4'hF, '0);
        wait_resp(1);
        wb_q.push_back('{we: 1'b0, addr: 26'h8, data: 32'h0, sel: 4'hF});
        rsp_q.push_back('{is_wr: 1'b0, resp: 2'b10, rdata: 32'h0});
        axi_issue(0, 0, 1, '0, '0, '0, 28'h20);
        wait_resp(1);
        mode = 2;
        wb_q.push_back('{we: 1'b0, addr: 26'hC, data: 32'h0, sel: 4'hF});
        rsp_q.push_back('{is_wr: 1'b0, resp: 2'b10, rdata: 32'h0});
        axi_issue(0, 0, 1, '0, '0, '0, 28'h30);
        wait_resp(1);
        total++;
        if (last_cyc_len != TO) begin
            bad++;
            $display("FAIL timeout_cyc_len got %0d want %0d", last_cyc_len, TO);
        end
        mode = 0;
    endtask

    task automatic test_backpressure();
        bit got;
        int base;
        mode = 0; stall_n = 0;
        bus.i_axi_bready = 1'b0;
        wb_q.push_back('{we: 1'b1, addr: 26'hC0, data: 32'h0BADF00D, sel: 4'hF});
        rsp_q.push_back('{is_wr: 1'b1, resp: 2'b00, rdata: 32'h0});
        axi_issue(1, 1, 0, 28'h300, 32'h0BADF00D, 4'hF, '0);
        got = 0;
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (bus.o_axi_bvalid) got = 1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL bp_bvalid got bvalid=0 want 1 within 30 cycles");
        end
        wb_q.push_back('{we: 1'b1, addr: 26'h80, data: 32'h11112222, sel: 4'h3});
        rsp_q.push_back('{is_wr: 1'b1, resp: 2'b00, rdata: 32'h0});
        @(posedge clk); #2;
        bus.i_axi_awvalid = 1'b1;
        bus.i_axi_awaddr  = 28'h200;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            total++;
            if (bus.o_axi_bvalid !== 1'b1 || bus.o_axi_bresp !== 2'b00 ||
                bus.o_axi_awready !== 1'b0 || bus.o_axi_wready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold[%0d] got bvalid=%b bresp=%b awready=%b wready=%b want 1/00/0/0",
                         i, bus.o_axi_bvalid, bus.o_axi_bresp, bus.o_axi_awready, bus.o_axi_wready);
            end
        end
        base = rsp_seen;
        @(posedge clk); #2;
        bus.i_axi_bready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.o_axi_awready) got = 1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL bp_aw_release got awready=0 want 1 within 20 cycles");
        end
        @(posedge clk); #2;
        bus.i_axi_awvalid = 1'b0;
        axi_issue(0, 1, 0, '0, 32'h11112222, 4'h3, '0);
        for (int i = 0; i < 40 && rsp_seen < base + 2; i++) @(negedge clk);
        total++;
        if (rsp_seen != base + 2) begin
            bad++;
            $display("FAIL bp_responses got %0d want %0d", rsp_seen - base, 2);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_async_reset();
        bit got;
        mode = 2; stall_n = 0;
        wb_q.push_back('{we: 1'b0, addr: 26'h14, data: 32'h0, sel: 4'hF});
        rsp_q.push_back('{is_wr: 1'b0, resp: 2'b10, rdata: 32'h0});
        axi_issue(0, 0, 1, '0, '0, '0, 28'h50);
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (bus.o_wb_cyc) got = 1;
        end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        total++;
        if (!got || bus.o_wb_cyc !== 1'b0 || bus.o_wb_stb !== 1'b0 || bus.o_wb_we !== 1'b0 ||
            bus.o_axi_rvalid !== 1'b0 || bus.o_axi_bvalid !== 1'b0 || bus.o_axi_arready !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got cyc_seen=%0d cyc=%b stb=%b rv=%b bv=%b arready=%b want 1/0/0/0/0/0",
                     got, bus.o_wb_cyc, bus.o_wb_stb, bus.o_axi_rvalid, bus.o_axi_bvalid, bus.o_axi_arready);
        end
        wb_q.delete();
        rsp_q.delete();
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (bus.o_axi_arready !== 1'b1 || bus.o_axi_rvalid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_ready got arready=%b rvalid=%b want 1/0", bus.o_axi_arready, bus.o_axi_rvalid);
        end
        mode = 0; rd_val = 32'hCAFEF00D;
        wb_q.push_back('{we: 1'b0, addr: 26'h11, data: 32'h0, sel: 4'hF});
        rsp_q.push_back('{is_wr: 1'b0, resp: 2'b00, rdata: 32'hCAFEF00D});
        axi_issue(0, 0, 1, '0, '0, '0, 28'h44);
        wait_resp(1);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_axi_awvalid = 1'b0; bus.i_axi_awaddr = '0; bus.i_axi_awprot = '0; bus.i_axi_awcache = '0;
        bus.i_axi_wvalid  = 1'b0; bus.i_axi_wdata  = '0; bus.i_axi_wstrb  = '0;
        bus.i_axi_bready  = 1'b1;
        bus.i_axi_arvalid = 1'b0; bus.i_axi_araddr = '0; bus.i_axi_arprot = '0; bus.i_axi_arcache = '0;
        bus.i_axi_rready  = 1'b1;
        bus.i_wb_stall = 1'b0; bus.i_wb_ack = 1'b0; bus.i_wb_err = 1'b0; bus.i_wb_data = '0;

        test_reset();
        test_single_write();
        test_read_stall();
        test_arbitration();
        test_error_timeout();
        test_backpressure();
        test_async_reset();

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got simulation still running want finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axil_wb_bridge.md
# axil_wb_bridge

Single-outstanding AXI4-Lite slave to pipelined Wishbone (B4) master bridge. It terminates the AXI-Lite slave interface on its upstream side and issues one Wishbone transaction at a time downstream. Every AXI-Lite request produces exactly one B or R response. A Wishbone bus timeout guarantees that no response waits without bound.

## Interface
Parameters:
- `C_AXI_ADDR_WIDTH`, default 28: AXI byte-address width (AW).
- `C_AXI_DATA_WIDTH`, default 32: fixed data width (DW); not overridable.
- `TIMEOUT`, default 8: maximum cycles `o_wb_cyc` may stay high before the bridge aborts the transaction. Legal range 2..15.

Ports:
- `i_clk`  in  1  clock; all state changes on the rising edge.
- `i_axi_reset_n`  in  1  reset; asynchronous assert, active-low.
- `i_axi_awvalid`, `o_axi_awready`  in/out  1  write-address handshake.
- `i_axi_awaddr`  in  AW  write byte address.
- `i_axi_awprot`  in  3  accepted, ignored.
- `i_axi_awcache`  in  4  accepted, ignored.
- `i_axi_wvalid`, `o_axi_wready`  in/out  1  write-data handshake.
- `i_axi_wdata`  in  32  write data.
- `i_axi_wstrb`  in  4  byte strobes.
- `o_axi_bvalid`, `i_axi_bready`  out/in  1  write-response handshake.
- `o_axi_bresp`  out  2  write response: 00 OKAY or 10 SLVERR.
- `i_axi_arvalid`, `o_axi_arready`  in/out  1  read-address handshake.
- `i_axi_araddr`  in  AW  read byte address.
- `i_axi_arprot`  in  3  accepted, ignored.
- `i_axi_arcache`  in  4  accepted, ignored.
- `o_axi_rvalid`, `i_axi_rready`  out/in  1  read-response handshake.
- `o_axi_rdata`  out  32  read data.
- `o_axi_rresp`  out  2  read response: 00 or 10.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we`  out  1  Wishbone master controls.
- `o_wb_addr`  out  AW-2  word address.
- `o_wb_data`  out  32  Wishbone write data.
- `o_wb_sel`  out  4  Wishbone byte selects.
- `i_wb_stall`, `i_wb_ack`, `i_wb_err`  in  1  Wishbone slave responses.
- `i_wb_data`  in  32  Wishbone read data.

## Operation
Holding registers:
- AW, W and AR each have a one-entry holding register with a full flag.
- `o_axi_awready` = !aw_full, `o_axi_wready` = !w_full, `o_axi_arready` = !ar_full.
- Each register captures on its valid&&ready handshake.
- AW and W are accepted independently, in either order.

FSM states are IDLE, WB_WAIT, BRESP and RRESP.
- **IDLE, write candidate:** aw_full&&w_full. Entering a write sets cyc=stb=we=1, addr=awaddr[AW-1:2], data=wdata, sel=wstrb.
- **IDLE, read candidate:** ar_full. Entering a read sets cyc=stb=1, we=0, addr=araddr[AW-1:2], sel=4'hf.
- **IDLE, both candidates ready:** a last_grant bit alternates priority. After reset, write wins first.
- **IDLE → WB_WAIT:** taken when a candidate is granted.
- **WB_WAIT, stb:** stb clears on the first cycle with stb&&!i_wb_stall.
- **WB_WAIT, ack:** i_wb_ack ends the cycle with resp=00. For a read, rdata is latched from i_wb_data.
- **WB_WAIT, err:** i_wb_err ends the cycle with resp=10 and rdata=0.
- **WB_WAIT, ack and err together:** err wins.
- **WB_WAIT, timeout:** the timer counts cycles with cyc high. When it reaches TIMEOUT-1 with no ack or err, the cycle ends with resp=10.
- **WB_WAIT, cycle end:** cyc=stb=0. Next state is BRESP (bvalid=1) for a write, RRESP (rvalid=1) for a read.
- **WB_WAIT, stray ack/err:** i_wb_ack or i_wb_err while cyc=0 is ignored.
- **BRESP:** on bvalid&&bready, clear bvalid, aw_full and w_full in the same edge, then return to IDLE.
- **RRESP:** on rvalid&&rready, clear rvalid and ar_full in the same edge, then return to IDLE.
- **Outstanding limit:** at most one write and one read are buffered, and only one is on the bus.
- **Response codes:** bresp and rresp never take 01 or 11.

## Timing
- **Reset:** i_axi_reset_n low immediately clears every output and internal flag, regardless of the clock.
  - All valids, cyc, stb and we go to 0. Resp and rdata go to 0. State goes to IDLE. last_grant is cleared so write wins first.
  - Ready outputs are 0 while reset is held.
  - Readies rise on the first clock edge after deassertion.
  - A Wishbone cycle in progress when reset asserts is dropped without a response.
- **Minimum write latency:**
  - Edge 0: AW and W handshake.
  - Cycle 1: stb.
  - Cycle 2: earliest ack.
  - Cycle 3: bvalid.
- **Minimum read latency:** same as a write, with rvalid in cycle 3.
- **Holding-register readiness:** awready and wready stay low from capture until the B handshake. arready stays low from capture until the R handshake.
- **Response stability:** bvalid/bresp and rvalid/rresp/rdata stay stable until their handshake.
- **Timeout:** with no ack, cyc stays high for exactly TIMEOUT cycles. The response valid rises on the following cycle.
- **Response interval:** no response valid is ever more than TIMEOUT+2 cycles after the bridge starts its Wishbone cycle.

## Test plan
- **Single write:** AW=0x100 and W=0xDEADBEEF with strb=4'hC, both in cycle 0; slave acks one cycle after stb with no stall → o_wb_addr=0x40, sel=4'hC, we=1; bvalid in cycle 3 with bresp=00.
- **Read with stall:** AR=0x8; slave stalls 2 cycles, then acks with data 0x12345678 → stb held 3 cycles; rvalid with rdata=0x12345678 and rresp=00; arready low until the R handshake.
- **Arbitration:** a write and a read are buffered simultaneously after reset → write issued first; after its B handshake the read is issued; repeating the same pair gives read first, then write.
- **Error and timeout:** i_wb_err on a write → bresp=10. A read with no ack and TIMEOUT=8 → cyc high exactly 8 cycles, then rresp=10 and rdata=0.
- **Backpressure:** bready held low 10 cycles → bvalid and bresp constant; AW/W readies stay low; a new AW is held off.
- **Async reset mid-cycle:** reset asserted while cyc=1 → cyc, stb and all valids go to 0 before the next edge; after release a fresh read completes normally.
